message_scheduler: RTL and testbench
====================================

# message_scheduler

Sequencer that decides which canned LCD message is shown and when. It sits between the rain sensor/Bluetooth control logic and the message ROM + LCD writer pair. It drives the ROM's 3-bit message code `flag_mensagem` and hands each new message to the LCD writer with a start/done handshake. Transient Bluetooth notices are held on screen for a minimum time, after which the display falls back to the steady-state weather/sensor message.

## Interface
- `HOLD_CYCLES`, default 100000000: minimum on-screen cycles for a transient (Bluetooth) message; 2 s at 50 MHz.
- `TIMEOUT_CYCLES`, default 1000000: LCD write watchdog limit. Used only with `MSG_TIMEOUT_EN`.
- `clk` in 1: system clock. One clock domain; everything is rising-edge.
- `rst` in 1: reset. Asynchronous, active-high.
- `rain` in 1: level, already synchronized; 1 = raining.
- `sensor_en` in 1: level; 0 = sensor disabled.
- `bt_on_req` in 1: single-cycle pulse; Bluetooth connected.
- `bt_off_req` in 1: single-cycle pulse; Bluetooth disconnected.
- `bt_rst_req` in 1: single-cycle pulse; Bluetooth reset.
- `lcd_done` in 1: single-cycle pulse from the LCD writer; all 32 characters written.
- `flag_mensagem` out 3: message code to the ROM. Registered.
- `lcd_start` out 1: single-cycle pulse; start writing the current `flag_mensagem`.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `lcd_timeout` out 1: sticky watchdog error flag.

## Operation
- Message codes:
  - 000 clear
  - 001 "Chovendo !"
  - 010 "Tempo Seco !"
  - 011 BT on
  - 100 BT off
  - 101 sensor off / BT off
  - 110 BT reset
- Steady code: `sensor_en`=0 → 101; else `rain`=1 → 001; else → 010.
- Pending transient register: valid bit + code.
  - Any request pulse loads it in any state; a newer request overwrites an older one.
  - Same-cycle priority: rst (110) > off (100) > on (011).
  - The register is cleared when IDLE consumes it, unless a new request arrives in that same cycle; the new request is then kept.
- `shown` register holds the last code written.
- FSM states:
  - IDLE:
    - If pending is valid → load its code into `flag_mensagem`, set transient=1, go to START.
    - Else if steady ≠ `shown` → load the steady code, set transient=0, go to START.
    - Else stay in IDLE.
  - START: `lcd_start`=1 for exactly one cycle; go to WRITE.
  - WRITE: wait for `lcd_done`, then update `shown` and go to HOLD if transient, otherwise to IDLE. `lcd_done` is ignored in all other states.
  - HOLD: count HOLD_CYCLES, then go to IDLE. HOLD is never pre-empted; requests arriving during HOLD stay pending.
- Steady inputs are sampled only in IDLE. Toggling them during START/WRITE/HOLD causes no glitch on `flag_mensagem`.
- A transient message is always followed by a rewrite of the steady message, because `shown` ≠ steady afterwards.

## Timing
- Reset values:
  - `flag_mensagem`=000, `lcd_start`=0, `busy`=0, `lcd_timeout`=0.
  - `shown`=000, pending cleared, state=IDLE.
- After reset, the first IDLE cycle always starts a steady write, since steady is never 000.
- Request-to-start latency:
  - Pulse in cycle N → pending valid in N+1.
  - IDLE decides in N+1.
  - `flag_mensagem` updates and `lcd_start`=1 in N+2.
- `flag_mensagem` is stable from the START cycle until the next IDLE decision.
- WRITE→IDLE or WRITE→HOLD happens on the edge that ends the `lcd_done` cycle.
- HOLD lasts exactly HOLD_CYCLES cycles; IDLE follows in the next cycle.
- Counter widths: `$clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1)`. No wrap; each counter clears on state entry.
- `rst` mid-operation: all registers return to their reset values immediately; any in-flight write and pending request are abandoned.

## Configuration
- Macro `MSG_TIMEOUT_EN`.
- Defined:
  - A WRITE counter runs. If TIMEOUT_CYCLES cycles pass in WRITE without `lcd_done`, go to IDLE, set `lcd_timeout`=1 (sticky until `rst`), and leave `shown` unchanged, so the write is retried.
- Undefined:
  - WRITE waits forever for `lcd_done`.
  - `lcd_timeout` is tied to 0.
  - No timeout counter is synthesized.

## Test plan
Run with HOLD_CYCLES=8 and TIMEOUT_CYCLES=20.
- Power-up: release `rst` with `sensor_en`=1, `rain`=0 → `lcd_start` 2 cycles later with `flag_mensagem`=010. Answer `lcd_done` → `busy`=0, no further starts.
- Transient hold: `bt_on_req` in IDLE → code 011 with `lcd_start` at N+2. After `lcd_done`, `busy` stays high 8 cycles, then code 010 is rewritten.
- Priority: `bt_on_req` and `bt_rst_req` in the same cycle → code 110 only. `bt_off_req` during HOLD → 100 is shown after the hold, then the steady code.
- Steady changes: set `rain`=1 during WRITE → no change until IDLE, then code 001. Set `sensor_en`=0 → code 101.
- Watchdog (`MSG_TIMEOUT_EN` defined): withhold `lcd_done` → after 20 WRITE cycles `lcd_timeout`=1 and the same code is restarted. Assert `rst` mid-WRITE → all outputs return to reset values.

Source files
------------

// File: rtl/message_scheduler.sv
// message_scheduler: chooses which canned LCD message is shown and when.
//
// Steady message (weather / sensor state) is rewritten whenever it differs from
// the last code written. Bluetooth notices are queued in a one-deep pending
// register (newest wins) and, once written, are held on screen for HOLD_CYCLES
// before the display falls back to the steady message.
//
// Optional feature: define MSG_TIMEOUT_EN to add an LCD write watchdog. When
// TIMEOUT_CYCLES cycles pass in WRITE without lcd_done, the FSM gives up,
// raises a sticky lcd_timeout, and the write is retried from IDLE.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   rain           1 = raining (synchronized level)
//   sensor_en      0 = sensor disabled (level)
//   bt_on_req      Bluetooth connected (pulse)
//   bt_off_req     Bluetooth disconnected (pulse)
//   bt_rst_req     Bluetooth reset (pulse)
//   lcd_done       LCD writer finished all 32 characters (pulse)
//   flag_mensagem  registered message code to the ROM
//   lcd_start      one-cycle start pulse to the LCD writer
//   busy           FSM is not idle
//   lcd_timeout    sticky watchdog error (tied 0 without MSG_TIMEOUT_EN)
module message_scheduler #(
  parameter int unsigned HOLD_CYCLES    = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rain,
  input  logic       sensor_en,
  input  logic       bt_on_req,
  input  logic       bt_off_req,
  input  logic       bt_rst_req,
  input  logic       lcd_done,
  output logic [2:0] flag_mensagem,
  output logic       lcd_start,
  output logic       busy,
  output logic       lcd_timeout
);

  localparam int unsigned MaxCycles =
      (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
`ifdef MSG_TIMEOUT_EN
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [2:0] CodeClear     = 3'b000;
  localparam logic [2:0] CodeRain      = 3'b001;
  localparam logic [2:0] CodeDry       = 3'b010;
  localparam logic [2:0] CodeBtOn      = 3'b011;
  localparam logic [2:0] CodeBtOff     = 3'b100;
  localparam logic [2:0] CodeSensorOff = 3'b101;
  localparam logic [2:0] CodeBtRst     = 3'b110;

  typedef enum logic [1:0] {StIdle, StStart, StWrite, StHold} state_e;

  state_e          state_q, state_d;
  logic [2:0]      flag_q, flag_d;
  logic [2:0]      shown_q, shown_d;
  logic            transient_q, transient_d;
  logic            pend_valid_q, pend_valid_d;
  logic [2:0]      pend_code_q, pend_code_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`ifdef MSG_TIMEOUT_EN
  logic            timeout_q, timeout_d;
`endif

  logic       req_any;
  logic [2:0] req_code;
  logic [2:0] steady;

  always_comb begin
    if (!sensor_en) begin
      steady = CodeSensorOff;
    end else if (rain) begin
      steady = CodeRain;
    end else begin
      steady = CodeDry;
    end
  end

  // Same-cycle request priority: reset > off > on.
  always_comb begin
    req_any = bt_rst_req | bt_off_req | bt_on_req;
    if (bt_rst_req) begin
      req_code = CodeBtRst;
    end else if (bt_off_req) begin
      req_code = CodeBtOff;
    end else begin
      req_code = CodeBtOn;
    end
  end

  always_comb begin
    state_d     = state_q;
    flag_d      = flag_q;
    shown_d     = shown_q;
    transient_d = transient_q;
`ifdef MSG_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          flag_d      = pend_code_q;
          transient_d = 1'b1;
          state_d     = StStart;
        end else if (steady != shown_q) begin
          flag_d      = steady;
          transient_d = 1'b0;
          state_d     = StStart;
        end
      end
      StStart: begin
        state_d = StWrite;
      end
      StWrite: begin
        if (lcd_done) begin
          shown_d = flag_q;
          state_d = transient_q ? StHold : StIdle;
`ifdef MSG_TIMEOUT_EN
        end else if (cnt_q == TimeoutLast) begin
          // shown is left untouched so IDLE retries the same write.
          timeout_d = 1'b1;
          state_d   = StIdle;
`endif
        end
      end
      StHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A request arriving in the consuming cycle survives the clear.
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    if (req_any) begin
      pend_valid_d = 1'b1;
      pend_code_d  = req_code;
    end else if (state_q == StIdle && pend_valid_q) begin
      pend_valid_d = 1'b0;
    end

    // Counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      flag_q       <= CodeClear;
      shown_q      <= CodeClear;
      transient_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= CodeClear;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag_d;
      shown_q      <= shown_d;
      transient_q  <= transient_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef MSG_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign lcd_timeout = timeout_q;
`else
  assign lcd_timeout = 1'b0;
`endif

  assign flag_mensagem = flag_q;
  assign lcd_start     = (state_q == StStart);
  assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_message_scheduler.sv
module tb_message_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rain;
  logic       sensor_en;
  logic       bt_on_req;
  logic       bt_off_req;
  logic       bt_rst_req;
  logic       lcd_done;
  logic [2:0] flag_mensagem;
  logic       lcd_start;
  logic       busy;
  logic       lcd_timeout;

  int total;
  int bad;

  message_scheduler #(
    .HOLD_CYCLES   (8),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rain         (rain),
    .sensor_en    (sensor_en),
    .bt_on_req    (bt_on_req),
    .bt_off_req   (bt_off_req),
    .bt_rst_req   (bt_rst_req),
    .lcd_done     (lcd_done),
    .flag_mensagem(flag_mensagem),
    .lcd_start    (lcd_start),
    .busy         (busy),
    .lcd_timeout  (lcd_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic done_pulse();
    lcd_done = 1'b1;
    step();
    lcd_done = 1'b0;
  endtask

  // Called in the first HOLD cycle: 7 more HOLD cycles, then IDLE.
  task automatic hold_wait(input string tag);
    for (int i = 0; i < 7; i++) begin
      step();
      check({tag, "_hold_busy"}, {3'b0, busy}, 4'h1);
    end
    step();
    check({tag, "_hold_end"}, {3'b0, busy}, 4'h0);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    rain       = 1'b0;
    sensor_en  = 1'b1;
    bt_on_req  = 1'b0;
    bt_off_req = 1'b0;
    bt_rst_req = 1'b0;
    lcd_done   = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_flag", {1'b0, flag_mensagem}, 4'h0);
    check("rst_start", {3'b0, lcd_start}, 4'h0);
    check("rst_busy", {3'b0, busy}, 4'h0);
    check("rst_timeout", {3'b0, lcd_timeout}, 4'h0);

    // Power-up steady write
    rst = 1'b0;
    check("pwr_idle", {3'b0, busy}, 4'h0);
    step();
    check("pwr_start", {3'b0, lcd_start}, 4'h1);
    check("pwr_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
    check("pwr_write_nostart", {3'b0, lcd_start}, 4'h0);
    check("pwr_write_busy", {3'b0, busy}, 4'h1);
    done_pulse();
    check("pwr_done_idle", {3'b0, busy}, 4'h0);
    repeat (4) step();
    check("pwr_quiet_start", {3'b0, lcd_start}, 4'h0);
    check("pwr_quiet_busy", {3'b0, busy}, 4'h0);

    // Stray lcd_done in IDLE is ignored
    done_pulse();
    step();
    check("stray_done", {3'b0, busy}, 4'h0);

    // Transient hold: BT on
    bt_on_req = 1'b1;
    step();
    bt_on_req = 1'b0;
    check("on_pend_idle", {3'b0, busy}, 4'h0);
    step();
    check("on_start", {3'b0, lcd_start}, 4'h1);
    check("on_flag", {1'b0, flag_mensagem}, 4'h3);
    step();
    done_pulse();
    check("on_hold_entry", {3'b0, busy}, 4'h1);
    hold_wait("on");
    check("on_flag_after_hold", {1'b0, flag_mensagem}, 4'h3);
    step();
    check("on_rewrite_start", {3'b0, lcd_start}, 4'h1);
    check("on_rewrite_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
    done_pulse();
    check("on_rewrite_idle", {3'b0, busy}, 4'h0);

    // Priority: on + rst same cycle -> 110
    bt_on_req  = 1'b1;
    bt_rst_req = 1'b1;
    step();
    bt_on_req  = 1'b0;
    bt_rst_req = 1'b0;
    step();
    check("prio_start", {3'b0, lcd_start}, 4'h1);
    check("prio_flag", {1'b0, flag_mensagem}, 4'h6);
    step();
    done_pulse();
    // bt_off during HOLD stays pending
    bt_off_req = 1'b1;
    step();
    bt_off_req = 1'b0;
    repeat (6) step();
    check("off_hold_busy", {3'b0, busy}, 4'h1);
    check("off_hold_flag", {1'b0, flag_mensagem}, 4'h6);
    step();
    check("off_hold_end", {3'b0, busy}, 4'h0);
    step();
    check("off_start", {3'b0, lcd_start}, 4'h1);
    check("off_flag", {1'b0, flag_mensagem}, 4'h4);
    step();
    done_pulse();
    hold_wait("off");
    step();
    check("off_steady_flag", {1'b0, flag_mensagem}, 4'h2);
    check("off_steady_start", {3'b0, lcd_start}, 4'h1);
    step();
    done_pulse();

    // Request arriving in the consuming IDLE cycle is kept
    bt_on_req = 1'b1;
    step();
    bt_on_req  = 1'b0;
    bt_off_req = 1'b1;
    step();
    bt_off_req = 1'b0;
    check("b2b_first_flag", {1'b0, flag_mensagem}, 4'h3);
    check("b2b_first_start", {3'b0, lcd_start}, 4'h1);
    step();
    done_pulse();
    hold_wait("b2b1");
    step();
    check("b2b_second_flag", {1'b0, flag_mensagem}, 4'h4);
    check("b2b_second_start", {3'b0, lcd_start}, 4'h1);
    step();
    done_pulse();
    hold_wait("b2b2");
    step();
    check("b2b_steady_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
    done_pulse();

    // Steady change during WRITE waits for IDLE
    bt_on_req = 1'b1;
    step();
    bt_on_req = 1'b0;
    step();
    step();
    rain = 1'b1;
    step();
    check("rain_write_flag", {1'b0, flag_mensagem}, 4'h3);
    done_pulse();
    hold_wait("rain");
    check("rain_hold_flag", {1'b0, flag_mensagem}, 4'h3);
    step();
    check("rain_start", {3'b0, lcd_start}, 4'h1);
    check("rain_flag", {1'b0, flag_mensagem}, 4'h1);
    step();
    done_pulse();
    sensor_en = 1'b0;
    step();
    check("sens_start", {3'b0, lcd_start}, 4'h1);
    check("sens_flag", {1'b0, flag_mensagem}, 4'h5);
    step();
    done_pulse();
    check("sens_idle", {3'b0, busy}, 4'h0);

    // Withheld lcd_done
    sensor_en = 1'b1;
    rain      = 1'b0;
    step();
    check("wd_start_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
`ifdef MSG_TIMEOUT_EN
    repeat (19) step();
    check("wd_pre_timeout", {3'b0, lcd_timeout}, 4'h0);
    check("wd_pre_busy", {3'b0, busy}, 4'h1);
    step();
    check("wd_timeout", {3'b0, lcd_timeout}, 4'h1);
    check("wd_idle", {3'b0, busy}, 4'h0);
    step();
    check("wd_retry_start", {3'b0, lcd_start}, 4'h1);
    check("wd_retry_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
    check("wd_sticky", {3'b0, lcd_timeout}, 4'h1);
`else
    repeat (25) step();
    check("nowd_busy", {3'b0, busy}, 4'h1);
    check("nowd_timeout", {3'b0, lcd_timeout}, 4'h0);
    check("nowd_start", {3'b0, lcd_start}, 4'h0);
`endif

    // Reset mid-WRITE abandons the write and the pending request
    bt_on_req = 1'b1;
    step();
    bt_on_req = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_flag", {1'b0, flag_mensagem}, 4'h0);
    check("mid_rst_start", {3'b0, lcd_start}, 4'h0);
    check("mid_rst_busy", {3'b0, busy}, 4'h0);
    check("mid_rst_timeout", {3'b0, lcd_timeout}, 4'h0);
    step();
    rst = 1'b0;
    check("post_rst_idle", {3'b0, busy}, 4'h0);
    step();
    check("post_rst_start", {3'b0, lcd_start}, 4'h1);
    check("post_rst_flag", {1'b0, flag_mensagem}, 4'h2);
    step();
    done_pulse();
    check("post_rst_done", {3'b0, busy}, 4'h0);
    step();
    check("post_rst_quiet", {3'b0, busy}, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
